muldiv_sequencer: RTL

Iterative signed multiply/divide engine with its own sequencing FSM and HI/LO registers. The multicycle control unit issues one-cycle start requests and waits in its mult/div states for the mult_stop/div_stop completion pulses. The control unit treats div_zero as its division-by-zero exception input. The mfhi/mflo paths read hi/lo directly.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_datapath.sv | 99 +++++++++
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and FSM state encoding for the iterative signed multiply/divide engine.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned ITER_DEF  = 32;
    localparam int unsigned CNT_W_DEF = $clog2(ITER_DEF) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_M,
        S_RUN_D,
        S_FIX,
        S_DONE,
        S_DZ
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude conversion, shift-add / restoring-divide step and final sign fix-up into HI/LO.
// MULDIV_EARLY_OUT_EN adds the tail_zero_c flag used to cut multiplies short.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             step,
    input  logic             fix,
    input  logic             op_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_EARLY_OUT_EN
    output logic             tail_zero_c,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    // acc: product for multiply, {remainder, quotient} for divide
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic             fits_c;
    logic [W2-1:0]    div_next_c;
    logic [W2-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    always_comb begin
        a_mag_c    = op_a[WIDTH-1] ? -op_a : op_a;
        b_mag_c    = op_b[WIDTH-1] ? -op_b : op_b;
        // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
        shifted_c  = acc[W2-1:WIDTH-1];
        trial_c    = shifted_c - {1'b0, mplier};
        fits_c     = (shifted_c >= {1'b0, mplier});
        div_next_c = {(fits_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0]),
                      acc[WIDTH-2:0], fits_c};
        prod_fix_c = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix_c  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix_c  = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign tail_zero_c = (mplier[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (init) begin
            sign_a <= op_a[WIDTH-1];
            sign_b <= op_b[WIDTH-1];
            mplier <= b_mag_c;
            if (op_div) begin
                acc   <= {{WIDTH{1'b0}}, a_mag_c};
                mcand <= '0;
            end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, a_mag_c};
            end
        end else if (step) begin
            if (op_div) begin
                acc <= div_next_c;
            end else begin
                acc    <= mplier[0] ? (acc + mcand) : acc;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end else if (fix) begin
            if (op_div) begin
                hi <= rem_fix_c;
                lo <= quo_fix_c;
            end else begin
                hi <= prod_fix_c[W2-1:WIDTH];
                lo <= prod_fix_c[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencing FSM for the iterative signed multiply/divide engine with HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ITER  = ITER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             mult_stop,
    output logic             div_stop,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             op_div;
    logic             op_div_next;
    logic             init_c;
    logic             step_c;
    logic             fix_c;
    logic             last_iter_c;
    logic             mul_exit_c;
    logic             mul_skip_c;
    logic             busy_c;
    logic             mult_stop_c;
    logic             div_stop_c;
    logic             div_zero_c;

    assign last_iter_c = (cnt == CNT_W'(ITER - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic tail_zero_c;
    assign mul_exit_c = last_iter_c || tail_zero_c;
    assign mul_skip_c = (op_b == '0);
`else
    assign mul_exit_c = last_iter_c;
    assign mul_skip_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_div    <= 1'b0;
            busy      <= 1'b0;
            mult_stop <= 1'b0;
            div_stop  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            op_div    <= op_div_next;
            busy      <= busy_c;
            mult_stop <= mult_stop_c;
            div_stop  <= div_stop_c;
            div_zero  <= div_zero_c;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        op_div_next = op_div;
        init_c      = 1'b0;
        step_c      = 1'b0;
        fix_c       = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Multiply takes priority when both requests arrive together
                if (start_mult) begin
                    init_c      = 1'b1;
                    op_div_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = mul_skip_c ? S_FIX : S_RUN_M;
                end else if (start_div) begin
                    op_div_next = 1'b1;
                    if (op_b == '0) begin
                        state_next = S_DZ;
                    end else begin
                        init_c     = 1'b1;
                        cnt_next   = '0;
                        state_next = S_RUN_D;
                    end
                end
            end
            S_RUN_M: begin
                step_c   = 1'b1;
                cnt_next = cnt + CNT_W'(1);
                if (mul_exit_c) state_next = S_FIX;
            end
            S_RUN_D: begin
                step_c   = 1'b1;
                cnt_next = cnt + CNT_W'(1);
                if (last_iter_c) state_next = S_FIX;
            end
            S_FIX: begin
                fix_c      = 1'b1;
                state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            S_DZ:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Outputs are registered from the upcoming state
        busy_c      = (state_next == S_RUN_M) || (state_next == S_RUN_D) ||
                      (state_next == S_FIX)   || (state_next == S_DONE);
        mult_stop_c = (state_next == S_DONE) && !op_div_next;
        div_stop_c  = ((state_next == S_DONE) && op_div_next) || (state_next == S_DZ);
        div_zero_c  = (state_next == S_DZ);
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .init        (init_c),
        .step        (step_c),
        .fix         (fix_c),
        .op_div      (op_div_next),
        .op_a        (op_a),
        .op_b        (op_b),
`ifdef MULDIV_EARLY_OUT_EN
        .tail_zero_c (tail_zero_c),
`endif
        .hi          (hi),
        .lo          (lo)
    );

endmodule
